fifo_rd_stream: RTL and testbench

// - Read-side drain engine for the async FIFO. Lives in the read clock domain.
// - Issues single-cycle read pops whenever the FIFO is non-empty and local credit exists.
// - Captures the registered rdata and presents it as a valid/ready stream.
// - No combinational path from m_ready to read.
// - Flush discards buffered and in-flight words without disturbing the FIFO protocol.

---
 rtl/fifo_rd_stream_pkg.sv | 12 +
 rtl/fifo_rd_skid.sv | 60 ++++++
 rtl/fifo_rd_stream.sv | 107 ++++++++++
 tb/tb_fifo_rd_stream.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_stream_pkg.sv
// Shared types and helpers for the async-FIFO read-side drain engine.
package fifo_rd_stream_pkg;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} rd_state_e;

  localparam int STAT_W = 32;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Circular skid buffer that absorbs FIFO read returns and presents the head word.
module fifo_rd_skid
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              push,
  input  logic [DATA_WIDTH-1:0]             push_data,
  input  logic                              pop,
  input  logic                              clr,
  output logic [cnt_w(BUF_DEPTH)-1:0]       occ,
  output logic [DATA_WIDTH-1:0]             head,
  output logic                              valid
);

  localparam int CW = cnt_w(BUF_DEPTH);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         cnt;
  logic                  pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop_ok = pop && (cnt != '0);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)   wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok) rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop_ok)      cnt <= cnt + 1'b1;
      else if (!push && pop_ok) cnt <= cnt - 1'b1;
    end
  end

  // Storage is data-only: pointers and count decide what is live.
  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (cnt <= CW'(BUF_DEPTH));
  end

  assign occ   = cnt;
  assign valid = (cnt != '0);
  assign head  = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-domain drain engine: pops the FIFO under local credit and streams words out.
// Optional handshake/stall statistics are enabled with FIFO_RD_STREAM_STATS_EN.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RD_LAT     = 1,
  parameter int BUF_DEPTH  = 3
) (
  input  logic                  rd_clk,
  input  logic                  rst,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  read,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  input  logic                  flush,
  output logic                  busy
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [STAT_W-1:0]     stat_words,
  output logic [STAT_W-1:0]     stat_stall
`endif
);

  localparam int CW = cnt_w(BUF_DEPTH);

  rd_state_e     state;
  logic [RD_LAT-1:0] rd_vld_p;
  logic [CW-1:0] infl;
  logic [CW-1:0] occ;
  logic [CW:0]   credit_sum;
  logic          ret;
  logic          push;
  logic          clr;
  logic          hs;

  always_comb begin
    infl = '0;
    for (int i = 0; i < RD_LAT; i++) infl = infl + CW'(rd_vld_p[i]);
  end

  // One extra bit keeps infl+occ from wrapping before the credit compare.
  assign credit_sum = {1'b0, infl} + {1'b0, occ};
  assign read = (state == RUN) && !empty && !flush &&
                (credit_sum < (CW+1)'(BUF_DEPTH));

  assign ret  = rd_vld_p[RD_LAT-1];
  assign push = ret && (state == RUN);
  assign clr  = flush && (state == RUN);
  assign hs   = m_valid && m_ready && !clr;
  assign busy = (state == FLUSH) || (infl != '0) || (occ != '0);

  // Return tag pipeline and run/flush control
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      state    <= RUN;
      rd_vld_p <= '0;
    end else begin
      rd_vld_p[0] <= read;
      for (int i = 1; i < RD_LAT; i++) rd_vld_p[i] <= rd_vld_p[i-1];
      case (state)
        RUN:     if (flush) state <= FLUSH;
        FLUSH:   if (infl == '0) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  fifo_rd_skid #(
    .DATA_WIDTH(DATA_WIDTH),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_skid (
    .clk      (rd_clk),
    .rst      (rst),
    .push     (push),
    .push_data(rdata),
    .pop      (hs),
    .clr      (clr),
    .occ      (occ),
    .head     (m_data),
    .valid    (m_valid)
  );

`ifdef FIFO_RD_STREAM_STATS_EN
  logic [STAT_W-1:0] words_q;
  logic [STAT_W-1:0] stall_q;

  // Saturating counters; flush deliberately leaves them alone.
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      words_q <= '0;
      stall_q <= '0;
    end else begin
      if (hs && (words_q != '1)) words_q <= words_q + 1'b1;
      if (m_valid && !m_ready && (stall_q != '1)) stall_q <= stall_q + 1'b1;
    end
  end

  assign stat_words = words_q;
  assign stat_stall = stall_q;
`else
  // Statistics build option off: no counters.
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed self-checking bench for fifo_rd_stream with a behavioural registered-output FIFO.
module tb_fifo_rd_stream;
  import fifo_rd_stream_pkg::*;

  logic       rd_clk = 1'b0;
  logic       rst = 1'b1;
  logic       empty = 1'b1;
  logic [7:0] rdata = 8'd0;
  logic       read;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready = 1'b0;
  logic       flush = 1'b0;
  logic       busy;
`ifdef FIFO_RD_STREAM_STATS_EN
  logic [31:0] stat_words;
  logic [31:0] stat_stall;
`endif

  int checks = 0;
  int failures = 0;
  int rd_while_empty = 0;
  logic [7:0] fifo_q[$];

  always #5 rd_clk = ~rd_clk;

  fifo_rd_stream #(.DATA_WIDTH(8), .RD_LAT(1), .BUF_DEPTH(3)) dut (
    .rd_clk (rd_clk),
    .rst    (rst),
    .empty  (empty),
    .rdata  (rdata),
    .read   (read),
    .m_valid(m_valid),
    .m_data (m_data),
    .m_ready(m_ready),
    .flush  (flush),
    .busy   (busy)
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    .stat_words(stat_words),
    .stat_stall(stat_stall)
`endif
  );

  // FIFO model: registered rdata and registered empty flag, reset with the DUT.
  always @(posedge rd_clk) begin
    if (rst) begin
      fifo_q.delete();
      empty <= 1'b1;
    end else begin
      if (read) begin
        if (fifo_q.size() == 0) rd_while_empty++;
        else rdata <= fifo_q.pop_front();
      end
      empty <= (fifo_q.size() == 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic push_seq(input int first, input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(8'(first + i));
  endtask

  task automatic test_reset();
    @(negedge rd_clk);
    @(negedge rd_clk);
    checks++; if (read !== 1'b0)    begin failures++; $display("FAIL reset_read: got %b expected 0", read); end
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
    checks++; if (m_data !== 8'd0)  begin failures++; $display("FAIL reset_m_data: got %0d expected 0", m_data); end
    checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0;
    @(negedge rd_clk);
  endtask

  task automatic test_basic();
    logic [7:0] exp_w [4] = '{8'd17, 8'd20, 8'd32, 8'd33};
    m_ready = 1'b1;
    fifo_q.push_back(8'd17); fifo_q.push_back(8'd20);
    fifo_q.push_back(8'd32); fifo_q.push_back(8'd33);
    for (int c = 1; c <= 9; c++) begin
      @(negedge rd_clk);
      checks++;
      if (read !== ((c >= 1 && c <= 4) ? 1'b1 : 1'b0)) begin
        failures++; $display("FAIL basic_read c%0d: got %b", c, read);
      end
      checks++;
      if (c >= 3 && c <= 6) begin
        if (m_valid !== 1'b1 || m_data !== exp_w[c-3]) begin
          failures++; $display("FAIL basic_data c%0d: got v=%b d=%0d expected v=1 d=%0d", c, m_valid, m_data, exp_w[c-3]);
        end
      end else if (m_valid !== 1'b0) begin
        failures++; $display("FAIL basic_idle c%0d: got m_valid=%b expected 0", c, m_valid);
      end
    end
    checks++; if (rd_while_empty != 0) begin failures++; $display("FAIL basic_underflow: got %0d expected 0", rd_while_empty); end
  endtask

  task automatic test_backpressure();
    int rd_cnt = 0;
    int exp_w = 1;
    int cyc = 0;
    m_ready = 1'b0;
    push_seq(1, 10);
    for (int c = 0; c < 8; c++) begin
      @(negedge rd_clk);
      if (read) rd_cnt++;
    end
    checks++; if (rd_cnt != 3) begin failures++; $display("FAIL bp_reads: got %0d expected 3", rd_cnt); end
    checks++; if (dut.occ !== 2'd3) begin failures++; $display("FAIL bp_occ: got %0d expected 3", dut.occ); end
    checks++; if (m_valid !== 1'b1 || m_data !== 8'd1) begin failures++; $display("FAIL bp_head: got v=%b d=%0d expected v=1 d=1", m_valid, m_data); end
    @(negedge rd_clk);
    checks++; if (m_data !== 8'd1 || read !== 1'b0) begin failures++; $display("FAIL bp_hold: got d=%0d read=%b expected d=1 read=0", m_data, read); end
    m_ready = 1'b1;
    while (exp_w <= 10 && cyc < 40) begin
      if (m_valid) begin
        checks++;
        if (m_data !== 8'(exp_w)) begin failures++; $display("FAIL bp_order: got %0d expected %0d", m_data, exp_w); end
        exp_w++;
      end
      cyc++;
      @(negedge rd_clk);
    end
    checks++; if (exp_w != 11 || cyc > 11) begin failures++; $display("FAIL bp_drain: got words=%0d cycles=%0d expected words=10 cycles<=11", exp_w - 1, cyc); end
  endtask

  task automatic test_toggle();
    int exp_w = 1;
    int cyc = 0;
    push_seq(1, 8);
    while (cyc < 60) begin
      @(negedge rd_clk);
      m_ready = (cyc % 2 == 0);
      checks++;
      if (read && (int'(dut.infl) + int'(dut.occ) >= 3)) begin
        failures++; $display("FAIL tog_credit: got read=1 with infl+occ=%0d expected below 3", int'(dut.infl) + int'(dut.occ));
      end
      if (m_valid && m_ready) begin
        checks++;
        if (m_data !== 8'(exp_w)) begin failures++; $display("FAIL tog_order: got %0d expected %0d", m_data, exp_w); end
        exp_w++;
      end
      cyc++;
    end
    checks++; if (exp_w != 9) begin failures++; $display("FAIL tog_count: got %0d expected 8", exp_w - 1); end
    m_ready = 1'b0;
  endtask

  task automatic test_flush();
    int cyc = 0;
    m_ready = 1'b0;
    fifo_q.push_back(8'd11); fifo_q.push_back(8'd12);
    fifo_q.push_back(8'd13); fifo_q.push_back(8'd99);
    @(negedge rd_clk);
    while (!(dut.occ == 2'd2 && dut.infl == 2'd1) && cyc < 20) begin
      @(negedge rd_clk);
      cyc++;
    end
    checks++; if (cyc >= 20) begin failures++; $display("FAIL flush_setup: got occ=%0d infl=%0d expected 2 and 1", dut.occ, dut.infl); end
    flush = 1'b1;
    m_ready = 1'b1;
    @(negedge rd_clk);
    flush = 1'b0;
    m_ready = 1'b0;
    checks++; if (m_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL flush_next: got v=%b busy=%b expected v=0 busy=1", m_valid, busy); end
    checks++; if (dut.state !== FLUSH) begin failures++; $display("FAIL flush_state: got %0d expected FLUSH", dut.state); end
    @(negedge rd_clk);
    checks++; if (dut.state !== RUN || m_valid !== 1'b0) begin failures++; $display("FAIL flush_back: got state=%0d v=%b expected RUN v=0", dut.state, m_valid); end
    m_ready = 1'b1;
    cyc = 0;
    while (!m_valid && cyc < 20) begin
      @(negedge rd_clk);
      cyc++;
    end
    checks++; if (m_valid !== 1'b1 || m_data !== 8'd99) begin failures++; $display("FAIL flush_resume: got v=%b d=%0d expected v=1 d=99", m_valid, m_data); end
    repeat (3) @(negedge rd_clk);
    checks++; if (m_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL flush_quiet: got v=%b busy=%b expected 0 0", m_valid, busy); end
    m_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    m_ready = 1'b1;
    push_seq(1, 6);
    repeat (3) @(negedge rd_clk);
    rst = 1'b1;
    @(negedge rd_clk);
    rst = 1'b0;
    checks++; if (read !== 1'b0)    begin failures++; $display("FAIL mrst_read: got %b expected 0", read); end
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL mrst_m_valid: got %b expected 0", m_valid); end
    checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL mrst_busy: got %b expected 0", busy); end
    checks++; if (dut.occ !== 2'd0) begin failures++; $display("FAIL mrst_occ: got %0d expected 0", dut.occ); end
    @(negedge rd_clk);
    checks++; if (m_valid !== 1'b0 || read !== 1'b0) begin failures++; $display("FAIL mrst_idle: got v=%b read=%b expected 0 0", m_valid, read); end
    m_ready = 1'b0;
  endtask

`ifdef FIFO_RD_STREAM_STATS_EN
  task automatic test_stats();
    int cyc = 0;
    rst = 1'b1;
    @(negedge rd_clk);
    rst = 1'b0;
    checks++; if (stat_words !== 32'd0 || stat_stall !== 32'd0) begin failures++; $display("FAIL stats_reset: got w=%0d s=%0d expected 0 0", stat_words, stat_stall); end
    m_ready = 1'b0;
    push_seq(100, 5);
    while (!m_valid && cyc < 20) begin
      @(negedge rd_clk);
      cyc++;
    end
    repeat (3) @(negedge rd_clk);
    m_ready = 1'b1;
    repeat (12) @(negedge rd_clk);
    checks++; if (stat_words !== 32'd5) begin failures++; $display("FAIL stats_words: got %0d expected 5", stat_words); end
    checks++; if (stat_stall !== 32'd3) begin failures++; $display("FAIL stats_stall: got %0d expected 3", stat_stall); end
    flush = 1'b1;
    @(negedge rd_clk);
    flush = 1'b0;
    repeat (3) @(negedge rd_clk);
    checks++; if (stat_words !== 32'd5 || stat_stall !== 32'd3) begin failures++; $display("FAIL stats_flush: got w=%0d s=%0d expected 5 3", stat_words, stat_stall); end
    m_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    repeat (3) @(negedge rd_clk);
    test_backpressure();
    repeat (3) @(negedge rd_clk);
    test_toggle();
    repeat (3) @(negedge rd_clk);
    test_flush();
    repeat (2) @(negedge rd_clk);
    test_mid_reset();
`ifdef FIFO_RD_STREAM_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
